count_cmp_irq: RTL and testbench
================================

# count_cmp_irq

Compare/capture stage that sits directly downstream of the user-area counter. It consumes the live `count` value, raises a programmable interrupt when the count reaches a compare value, and captures the count on a rising edge of an external pad input. Firmware configures and services it through its own Wishbone slave window, and `irq_o` drives one of the user-area IRQ lines.

## Interface
- `BITS`, 32: width of `count_i`, CMP and CAP; 1..32, zero-extended into 32-bit reads.
- `BASE_ADR`, 32'h3000_0100: base of the 32-byte register window.
- `wb_clk_i`  in  1  single clock; all logic on rising edge.
- `wb_rst_ni`  in  1  reset, asynchronous assert, active-low; release synchronous to `wb_clk_i` is upstream's job.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone classic controls.
- `wbs_sel_i`  in  4  byte strobes.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  single-cycle acknowledge.
- `wbs_dat_o`  out  32  read data, valid while `wbs_ack_o`=1, else 0.
- `count_i`  in  BITS  live counter value, synchronous to `wb_clk_i`.
- `capture_i`  in  1  asynchronous pad input; rising edge triggers capture.
- `irq_o`  out  1  registered level interrupt.

## Operation
- Registers, offset from `BASE_ADR`:
  - 0x00 CTRL (RW): bit0 CMP_EN, bit1 CAP_EN, bit2 ONESHOT; other bits read 0.
  - 0x04 CMP (RW): compare value, BITS wide.
  - 0x08 CAP (RO): last captured count.
  - 0x0C STATUS (W1C): bit0 CMP_HIT, bit1 CAP_VALID, bit2 CAP_OVR.
  - 0x10 IRQ_EN (RW): bits[2:0] mask STATUS bits.
  - 0x14–0x1C: read 0, writes ignored, still acked.
- Byte strobes apply to every RW register; a W1C clears a STATUS bit only when its byte strobe is set.
- Addresses outside the window: never acked (another slave owns them).
- Compare: `count_prev` holds `count_i` from the previous cycle. A match is `count_i == CMP && count_prev != CMP && CMP_EN`. On a match, CMP_HIT is set. If ONESHOT=1, CMP_EN is cleared in the same cycle.
  - A stalled count sitting on CMP produces exactly one hit.
- Capture: `capture_i` passes through a 2-flop synchronizer and an edge flop. On a synchronized rising edge with CAP_EN=1:
  - CAP <= `count_i`, CAP_VALID set.
  - If CAP_VALID was already 1, CAP_OVR is also set. CAP is still overwritten.
- If a hardware set and a firmware W1C hit the same bit in the same cycle, the set wins.
- `irq_o` <= |(STATUS & IRQ_EN[2:0]), registered.
- Reset values: CTRL=0, CMP=0, CAP=0, STATUS=0, IRQ_EN=0, `count_prev`=0, sync flops=0, `wbs_ack_o`=0, `wbs_dat_o`=0, `irq_o`=0.

## Timing
- Wishbone handshake:
  - Cycle of request: `valid` = cyc & stb & address in window, with `wbs_ack_o`=0.
  - `wbs_ack_o` goes 1 on the next edge and stays high for exactly one cycle.
  - A master holding stb across the ack sees ack low for one cycle, then the next ack. Minimum transaction period is 2 cycles.
  - Write data lands in the register on the same edge that raises ack.
  - Read data reflects register state before that edge.
- Compare latency: match at cycle N → CMP_HIT=1 after edge N+1 → `irq_o`=1 after edge N+2.
- Capture latency: the first sampling edge that sees `capture_i`=1 is E. Synchronized edge detected after E+2; CAP/CAP_VALID updated at E+3; `irq_o` at E+4. Captured value is `count_i` at edge E+3.
- Capture pulses shorter than 2 clock periods are not guaranteed to be seen.
- A CMP write takes effect for compares starting the cycle after ack.
- Reset asserted mid-transaction: ack drops immediately and all state returns to reset values. No ack is issued for the aborted access.

## Test plan
- Reset: hold `wb_rst_ni`=0, toggle the clock → all outputs 0; read every register → 0.
- Compare: write CMP=0x10, IRQ_EN=1, CTRL=1; ramp `count_i` from 0 → CMP_HIT set exactly 1 cycle after `count_i`=0x10 and `irq_o` 2 cycles after.
  - Hold `count_i`=0x10 for 5 cycles → still a single hit.
  - Write STATUS=1 → `irq_o` drops 1 cycle after ack.
- Oneshot: CTRL=0x5, count wraps past CMP twice → one hit only; CTRL reads 0x4 afterwards.
- Capture/overrun: CTRL=2, pulse `capture_i` (3 cycles wide) while `count_i`=0x55, then again at 0x99 → CAP=0x99, STATUS=0x6.
- Set-vs-clear: W1C of CMP_HIT in the same cycle as a new match → CMP_HIT remains 1.
- Bus: sel=4'b0001 write of 0xAABBCCDD to CMP → CMP=0xDD. Read 0x14 → 0. Access to `BASE_ADR`+0x40 → no ack within 4 cycles.

Source files
------------

// File: rtl/count_cmp_irq.sv
// Compare/capture stage behind the user-area counter: compare interrupt, pad-triggered
// count capture, and a 32-byte Wishbone register window for firmware.
module count_cmp_irq #(
  parameter int unsigned BITS     = 32,
  parameter logic [31:0] BASE_ADR = 32'h3000_0100
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [BITS-1:0] count_i,
  input  logic            capture_i,
  output logic            irq_o
);

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_CMP    = 3'd1;
  localparam logic [2:0] REG_CAP    = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;
  localparam logic [2:0] REG_IRQ_EN = 3'd4;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  logic [2:0]      ctrl_q, ctrl_d;
  logic [BITS-1:0] cmp_q, cmp_d;
  logic [BITS-1:0] cap_q, cap_d;
  logic [BITS-1:0] count_prev_q;
  logic [2:0]      status_q, status_d, status_set, status_clr;
  logic [2:0]      irq_en_q, irq_en_d;
  logic            cap_sync_p0, cap_sync_p1, cap_sync_p2, cap_rise_p3;
  logic            in_window, req_vld, wr_en, cmp_match, cap_evt;
  logic [2:0]      reg_idx;
  logic [31:0]     rd_data;
  logic            unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  // Holding ack low for the cycle after an ack gives the 2-cycle minimum period.
  assign in_window = (wbs_adr_i[31:5] == BASE_ADR[31:5]);
  assign req_vld   = wbs_cyc_i & wbs_stb_i & in_window & ~wbs_ack_o;
  assign wr_en     = req_vld & wbs_we_i;
  assign reg_idx   = wbs_adr_i[4:2];

  assign cmp_match = (count_i == cmp_q) && (count_prev_q != cmp_q) && ctrl_q[0];
  assign cap_evt   = cap_rise_p3 & ctrl_q[1];

  always_comb begin
    rd_data = '0;
    case (reg_idx)
      REG_CTRL:   rd_data = {29'd0, ctrl_q};
      REG_CMP:    rd_data = 32'(cmp_q);
      REG_CAP:    rd_data = 32'(cap_q);
      REG_STATUS: rd_data = {29'd0, status_q};
      REG_IRQ_EN: rd_data = {29'd0, irq_en_q};
      default:    rd_data = '0;
    endcase
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    cmp_d    = cmp_q;
    irq_en_d = irq_en_q;
    cap_d    = cap_q;
    if (wr_en && reg_idx == REG_CTRL && wbs_sel_i[0]) ctrl_d = wbs_dat_i[2:0];
    if (wr_en && reg_idx == REG_CMP)
      cmp_d = BITS'(merge_bytes(32'(cmp_q), wbs_dat_i, wbs_sel_i));
    if (wr_en && reg_idx == REG_IRQ_EN && wbs_sel_i[0]) irq_en_d = wbs_dat_i[2:0];
    // Oneshot disarm overrides a firmware CTRL write in the same cycle.
    if (cmp_match && ctrl_q[2]) ctrl_d[0] = 1'b0;
    if (cap_evt) cap_d = count_i;

    status_clr = '0;
    if (wr_en && reg_idx == REG_STATUS && wbs_sel_i[0]) status_clr = wbs_dat_i[2:0];
    status_set = {cap_evt & status_q[1], cap_evt, cmp_match};
    status_d   = (status_q & ~status_clr) | status_set;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ctrl_q       <= '0;
      cmp_q        <= '0;
      cap_q        <= '0;
      status_q     <= '0;
      irq_en_q     <= '0;
      count_prev_q <= '0;
      cap_sync_p0  <= 1'b0;
      cap_sync_p1  <= 1'b0;
      cap_sync_p2  <= 1'b0;
      cap_rise_p3  <= 1'b0;
      wbs_ack_o    <= 1'b0;
      wbs_dat_o    <= '0;
      irq_o        <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      cmp_q        <= cmp_d;
      cap_q        <= cap_d;
      status_q     <= status_d;
      irq_en_q     <= irq_en_d;
      count_prev_q <= count_i;
      // p0/p1 synchronize the pad, p2 is the edge flop, p3 the registered rise.
      cap_sync_p0  <= capture_i;
      cap_sync_p1  <= cap_sync_p0;
      cap_sync_p2  <= cap_sync_p1;
      cap_rise_p3  <= cap_sync_p1 & ~cap_sync_p2;
      wbs_ack_o    <= req_vld;
      wbs_dat_o    <= (req_vld && !wbs_we_i) ? rd_data : '0;
      irq_o        <= |(status_q & irq_en_q);
    end
  end

endmodule

// File: tb/tb_count_cmp_irq.sv
// Directed bench for count_cmp_irq: register-map model checked every cycle plus
// hand-computed register and interrupt expectations.
module tb_count_cmp_irq;

  localparam int unsigned BITS = 32;
  localparam logic [31:0] BASE = 32'h3000_0100;

  logic        clk, rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w;
  logic        ack;
  logic [31:0] dat_r;
  logic [31:0] count;
  logic        capture;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  count_cmp_irq #(.BITS(BITS), .BASE_ADR(BASE)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat_w),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_r),
    .count_i  (count),
    .capture_i(capture),
    .irq_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Register-map model: index 0 CTRL, 1 CMP, 2 CAP, 3 STATUS, 4 IRQ_EN, 5..7 empty.
  logic [31:0] m_reg [0:7];
  logic [31:0] m_prev, m_dat, m_pre_ctrl;
  logic [3:0]  m_hist;
  logic        m_ack, m_irq, m_req, m_hit, m_cap, m_ovr;
  logic [2:0]  m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      m_prev = '0; m_hist = '0; m_ack = 1'b0; m_dat = '0; m_irq = 1'b0;
    end else begin
      m_idx      = adr[4:2];
      m_req      = cyc && stb && (adr[31:5] == BASE[31:5]) && !m_ack;
      m_pre_ctrl = m_reg[0];
      m_hit      = (count == m_reg[1]) && (m_prev != m_reg[1]) && m_reg[0][0];
      m_cap      = m_hist[2] && !m_hist[3] && m_reg[0][1];
      m_ovr      = m_cap && m_reg[3][1];
      m_irq      = |(m_reg[3] & m_reg[4]);
      m_dat      = (m_req && !we) ? m_reg[m_idx] : 32'd0;
      if (m_req && we) begin
        if (m_idx == 3'd0 || m_idx == 3'd1 || m_idx == 3'd4) begin
          for (int b = 0; b < 4; b++)
            if (sel[b]) m_reg[m_idx][8*b +: 8] = dat_w[8*b +: 8];
          if (m_idx != 3'd1) m_reg[m_idx] = m_reg[m_idx] & 32'h7;
        end
        if (m_idx == 3'd3 && sel[0]) m_reg[3] = m_reg[3] & ~(dat_w & 32'h7);
      end
      if (m_hit) m_reg[3][0] = 1'b1;
      if (m_hit && m_pre_ctrl[2]) m_reg[0][0] = 1'b0;
      if (m_cap) begin
        m_reg[2] = count;
        m_reg[3][1] = 1'b1;
        if (m_ovr) m_reg[3][2] = 1'b1;
      end
      m_ack  = m_req;
      m_prev = count;
      m_hist = {m_hist[2:0], capture};
    end
  end

  always @(negedge clk) begin
    check("ack_model", 32'(ack), 32'(m_ack));
    check("dat_model", dat_r, m_dat);
    check("irq_model", 32'(irq), 32'(m_irq));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit cnt_en, input logic [31:0] cnt_val,
                         output logic [31:0] rd, output bit acked);
    step();
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    if (cnt_en) count = cnt_val;
    acked = 1'b0; rd = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack) begin acked = 1'b1; rd = dat_r; break; end
    end
    step();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd; bit acked;
    wb_xfer(1'b1, BASE + off, d, s, 1'b0, 32'd0, rd, acked);
    check("wr_ack", 32'(acked), 32'd1);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] rd; bit acked;
    wb_xfer(1'b0, BASE + off, 32'd0, 4'hf, 1'b0, 32'd0, rd, acked);
    check("rd_ack", 32'(acked), 32'd1);
    check(name, rd, exp);
  endtask

  task automatic pulse_cap();
    step(); capture = 1'b1;
    repeat (3) @(posedge clk);
    #1 capture = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd; bit acked;
    rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
    adr = '0; dat_w = '0; count = '0; capture = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", dat_r, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    step(); rst_n = 1'b1;
    for (int r = 0; r < 8; r++) rd_chk("rst_reg", 32'(r * 4), 32'd0);

    // Compare: ramp into CMP, hold it, then clear
    wr(32'h04, 32'h10, 4'hf);
    wr(32'h10, 32'h1, 4'hf);
    wr(32'h00, 32'h1, 4'hf);
    for (int v = 1; v <= 16; v++) begin
      step(); count = 32'(v);
      @(negedge clk); check("irq_ramp", 32'(irq), 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk); check("irq_hold", 32'(irq), 32'(i >= 1));
    end
    rd_chk("status_hit", 32'h0C, 32'h1);
    wr(32'h0C, 32'h1, 4'h1);
    @(negedge clk); check("irq_cleared", 32'(irq), 32'd0);
    rd_chk("status_no_rehit", 32'h0C, 32'h0);

    // Oneshot
    wr(32'h00, 32'h5, 4'hf);
    for (int v = 15; v <= 17; v++) begin step(); count = 32'(v); end
    repeat (2) step();
    rd_chk("ctrl_oneshot", 32'h00, 32'h4);
    rd_chk("status_oneshot", 32'h0C, 32'h1);
    wr(32'h0C, 32'h1, 4'h1);
    for (int v = 15; v <= 17; v++) begin step(); count = 32'(v); end
    repeat (3) step();
    rd_chk("status_disarmed", 32'h0C, 32'h0);

    // Capture and overrun
    wr(32'h00, 32'h2, 4'hf);
    wr(32'h10, 32'h6, 4'hf);
    step(); count = 32'h55;
    pulse_cap();
    rd_chk("cap_first", 32'h08, 32'h55);
    rd_chk("status_cap1", 32'h0C, 32'h2);
    step(); count = 32'h99;
    pulse_cap();
    rd_chk("cap_second", 32'h08, 32'h99);
    rd_chk("status_ovr", 32'h0C, 32'h6);
    @(negedge clk); check("irq_cap", 32'(irq), 32'd1);
    wr(32'h0C, 32'h7, 4'h1);
    rd_chk("status_cap_clr", 32'h0C, 32'h0);

    // Set wins over W1C in the same cycle
    wr(32'h00, 32'h1, 4'hf);
    wb_xfer(1'b1, BASE + 32'h0C, 32'h1, 4'h1, 1'b1, 32'h10, rd, acked);
    check("w1c_ack", 32'(acked), 32'd1);
    rd_chk("status_set_wins", 32'h0C, 32'h1);

    // Bus details
    wr(32'h04, 32'hAABB_CCDD, 4'b0001);
    rd_chk("cmp_bytesel", 32'h04, 32'hDD);
    rd_chk("reg_14", 32'h14, 32'h0);
    wr(32'h18, 32'hFFFF_FFFF, 4'hf);
    rd_chk("reg_18", 32'h18, 32'h0);
    wb_xfer(1'b0, BASE + 32'h40, 32'd0, 4'hf, 1'b0, 32'd0, rd, acked);
    check("out_of_window_ack", 32'(acked), 32'd0);

    // Reset during a transaction
    step(); cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hf;
    step();
    check("ack_pre_rst", 32'(ack), 32'd1);
    rst_n = 1'b0; #1;
    check("ack_on_rst", 32'(ack), 32'd0);
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd_chk("ctrl_after_rst", 32'h00, 32'h0);
    rd_chk("cmp_after_rst", 32'h04, 32'h0);
    rd_chk("status_after_rst", 32'h0C, 32'h0);
    rd_chk("irqen_after_rst", 32'h10, 32'h0);

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
